fifo_wr_feeder: RTL

//   Write-side master for the synchronous byte FIFO.
//   - Accepts an upstream valid/ready stream and drives the FIFO write port
//     (write_en, data_in), honouring full.
//   - A 2-entry skid buffer gives a registered upstream ready (s_ready), so

---
 rtl/fifo_wr_feeder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_feeder.sv
// fifo_wr_feeder: write-side master for a synchronous byte FIFO.
// A 2-entry skid buffer decouples the upstream valid/ready stream from the
// FIFO's same-cycle full flag. Upstream ready is a flop, so full never has a
// combinational path to the producer. Write and stall statistics are kept
// alongside the datapath.
module fifo_wr_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  full,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [1:0]            occupancy
);

  // Number of entries currently held in the skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

  occ_state_t            r_state;
  occ_state_t            w_state_next;
  logic                  r_s_ready;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [0:1];
  logic [CNT_WIDTH-1:0]  r_wr_count;
  logic [CNT_WIDTH-1:0]  r_stall_count;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_stall;
  logic                  w_nonempty;

  assign w_nonempty = (r_state != ST_EMPTY);

  // Accept upstream only while ready; the TWO guard is redundant with the
  // registered ready but keeps a full buffer from ever being overwritten.
  assign w_push  = s_valid && r_s_ready && (r_state != ST_TWO);

  // A write is only offered when the FIFO can take it, so every strobe lands.
  assign w_pop   = w_nonempty && !full;
  assign w_stall = w_nonempty && full;

  // Occupancy transition: push and pop together leave the count unchanged.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_push && !w_pop) begin
          w_state_next = ST_TWO;
        end else if (w_pop && !w_push) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_next = ST_ONE;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
  end

  // Occupancy FSM, buffer pointers and the registered upstream ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_s_ready <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      // Ready reflects the occupancy that will exist after this edge, so it
      // drops as the buffer fills and returns the cycle after a drain.
      r_s_ready <= (w_state_next != ST_TWO);
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Skid storage: each entry loads when the write pointer selects it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    // Capture the accepted upstream beat into this slot.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mem[gi] <= '0;
      end else if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_mem[gi] <= s_data;
      end
    end
  end

  // Write counter wraps; stall counter sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_count    <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
      if (w_stall && (r_stall_count != {CNT_WIDTH{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign s_ready     = r_s_ready;
  assign write_en    = w_pop;
  // Head entry is presented only when something is buffered; otherwise zero.
  assign data_in     = w_nonempty ? r_mem[r_rd_ptr] : '0;
  assign wr_count    = r_wr_count;
  assign stall_count = r_stall_count;
  assign occupancy   = r_state;

endmodule
